// File: rtl/tap_pkg.sv
// Shared types and constants for the parametrised JTAG TAP controller.
// State codes match the 4-bit observation encoding of the existing route block.
package tap_pkg;

  typedef enum logic [3:0] {
    EX2DR = 4'h0,
    EX1DR = 4'h1,
    SHDR  = 4'h2,
    PSDR  = 4'h3,
    SELIR = 4'h4,
    UPDR  = 4'h5,
    CAPDR = 4'h6,
    SELDR = 4'h7,
    EX2IR = 4'h8,
    EX1IR = 4'h9,
    SHIR  = 4'hA,
    PSIR  = 4'hB,
    RTI   = 4'hC,
    UPIR  = 4'hD,
    CAPIR = 4'hE,
    TLR   = 4'hF
  } tap_state_e;

  typedef enum logic [1:0] {
    DR_BYPASS = 2'd0,
    DR_IDCODE = 2'd1,
    DR_USER   = 2'd2
  } dr_sel_e;

  localparam int IDCODE    = 1;
  localparam int USER_BASE = 2;

  // BYPASS is the all-ones instruction for whatever IR width is in use.
  function automatic logic [31:0] bypass_code(input int ir_w);
    return (32'd1 << ir_w) - 32'd1;
  endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 sixteen-state TAP controller: state register and TMS-driven
// next-state logic only; all data-path actions live in the parent.
module tap_fsm
  import tap_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tms,
  output tap_state_e o_state,
  output tap_state_e o_state_nxt
);

  tap_state_e r_state;
  tap_state_e w_state_nxt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= TLR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TLR:   w_state_nxt = i_tms ? TLR   : RTI;
      RTI:   w_state_nxt = i_tms ? SELDR : RTI;
      SELDR: w_state_nxt = i_tms ? SELIR : CAPDR;
      SELIR: w_state_nxt = i_tms ? TLR   : CAPIR;
      CAPDR: w_state_nxt = i_tms ? EX1DR : SHDR;
      SHDR:  w_state_nxt = i_tms ? EX1DR : SHDR;
      EX1DR: w_state_nxt = i_tms ? UPDR  : PSDR;
      PSDR:  w_state_nxt = i_tms ? EX2DR : PSDR;
      EX2DR: w_state_nxt = i_tms ? UPDR  : SHDR;
      UPDR:  w_state_nxt = i_tms ? SELDR : RTI;
      CAPIR: w_state_nxt = i_tms ? EX1IR : SHIR;
      SHIR:  w_state_nxt = i_tms ? EX1IR : SHIR;
      EX1IR: w_state_nxt = i_tms ? UPIR  : PSIR;
      PSIR:  w_state_nxt = i_tms ? EX2IR : PSIR;
      EX2IR: w_state_nxt = i_tms ? UPIR  : SHIR;
      UPIR:  w_state_nxt = i_tms ? SELDR : RTI;
      default: w_state_nxt = TLR;
    endcase
  end

  assign o_state     = r_state;
  assign o_state_nxt = w_state_nxt;

endmodule

// File: rtl/tap_ctrl_param.sv
// Parametrised JTAG TAP: instruction register, BYPASS/IDCODE/USERk data
// registers sharing one DR shift chain, and the serial TDO mux.
module tap_ctrl_param
  import tap_pkg::*;
#(
  parameter int          IR_W       = 4,
  parameter int          USER_W     = 8,
  parameter int          NUM_USER   = 2,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
  input  logic                         GCLK,
  input  logic                         TRST_N,
  input  logic                         TMS,
  input  logic                         TDI,
  output logic                         TDO,
  output logic                         TDO_EN,
  output logic [3:0]                   state_obs,
  output logic [IR_W-1:0]              ir_obs,
  input  logic [NUM_USER*USER_W-1:0]   user_in,
  output logic [NUM_USER*USER_W-1:0]   user_out,
  output logic [NUM_USER-1:0]          user_upd
);

  // One physical DR chain long enough for IDCODE or the widest user register.
  localparam int DR_W  = (USER_W > 32) ? USER_W : 32;
  localparam int DR_IW = $clog2(DR_W);
  localparam logic [IR_W-1:0] BYPASS_CODE = IR_W'(bypass_code(IR_W));

  tap_state_e w_state;
  tap_state_e w_state_nxt;

  logic [IR_W-1:0]            r_ir;
  logic [IR_W-1:0]            r_ir_sr;
  logic [DR_W-1:0]            r_dr_sr;
  logic [NUM_USER*USER_W-1:0] r_user_out;
  logic [NUM_USER-1:0]        r_user_upd;

  dr_sel_e                    w_sel;
  logic [NUM_USER-1:0]        w_user_hit;
  logic [DR_W-1:0]            w_dr_cap;
  logic [DR_W-1:0]            w_dr_shift;
  logic [DR_IW-1:0]           w_dr_msb;
  logic                       w_tdo;

  tap_fsm u_fsm (
    .i_clk       (GCLK),
    .i_rst_n     (TRST_N),
    .i_tms       (TMS),
    .o_state     (w_state),
    .o_state_nxt (w_state_nxt)
  );

  // Instruction decode; BYPASS wins if a user code would alias all-ones.
  always_comb begin
    w_sel      = DR_BYPASS;
    w_user_hit = '0;
    if (r_ir == BYPASS_CODE) begin
      w_sel = DR_BYPASS;
    end else if (r_ir == IR_W'(IDCODE)) begin
      w_sel = DR_IDCODE;
    end else begin
      for (int k = 0; k < NUM_USER; k++) begin
        if (r_ir == IR_W'(USER_BASE + k)) begin
          w_sel         = DR_USER;
          w_user_hit[k] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_dr_cap = '0;
    w_dr_msb = '0;
    case (w_sel)
      DR_IDCODE: begin
        w_dr_cap[31:0] = IDCODE_VAL;
        w_dr_msb       = DR_IW'(31);
      end
      DR_USER: begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (w_user_hit[k]) begin
            w_dr_cap[USER_W-1:0] = user_in[k*USER_W +: USER_W];
          end
        end
        w_dr_msb = DR_IW'(USER_W - 1);
      end
      default: begin
        w_dr_cap = '0;
        w_dr_msb = '0;
      end
    endcase
  end

  // TDI enters at the top of the selected register's length, not the chain's.
  always_comb begin
    w_dr_shift           = {1'b0, r_dr_sr[DR_W-1:1]};
    w_dr_shift[w_dr_msb] = TDI;
  end

  always_ff @(posedge GCLK) begin
    if (!TRST_N) begin
      r_ir_sr <= '0;
    end else if (w_state == CAPIR) begin
      r_ir_sr <= IR_W'(2'b01);
    end else if (w_state == SHIR) begin
      r_ir_sr <= {TDI, r_ir_sr[IR_W-1:1]};
    end
  end

  always_ff @(posedge GCLK) begin
    if (!TRST_N) begin
      r_ir <= IR_W'(IDCODE);
    end else if (w_state_nxt == TLR) begin
      r_ir <= IR_W'(IDCODE);
    end else if (w_state == UPIR) begin
      r_ir <= r_ir_sr;
    end
  end

  always_ff @(posedge GCLK) begin
    if (!TRST_N) begin
      r_dr_sr <= '0;
    end else if (w_state == CAPDR) begin
      r_dr_sr <= w_dr_cap;
    end else if (w_state == SHDR) begin
      r_dr_sr <= w_dr_shift;
    end
  end

  // Update pulse lasts exactly the cycle after the UPDR edge.
  always_ff @(posedge GCLK) begin
    if (!TRST_N) begin
      r_user_out <= '0;
      r_user_upd <= '0;
    end else begin
      r_user_upd <= '0;
      if (w_state == UPDR) begin
        for (int k = 0; k < NUM_USER; k++) begin
          if (w_user_hit[k]) begin
            r_user_out[k*USER_W +: USER_W] <= r_dr_sr[USER_W-1:0];
            r_user_upd[k]                  <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_tdo = 1'b0;
    if (w_state == SHIR) begin
      w_tdo = r_ir_sr[0];
    end else if (w_state == SHDR) begin
      w_tdo = r_dr_sr[0];
    end
  end

  assign TDO       = w_tdo;
  assign TDO_EN    = (w_state == SHIR) || (w_state == SHDR);
  assign state_obs = w_state;
  assign ir_obs    = r_ir;
  assign user_out  = r_user_out;
  assign user_upd  = r_user_upd;

endmodule
